// File: rtl/ram_access_arbiter_pkg.sv
// Shared encodings and default sizes for the RAM access arbiter
// and the RAM array clients that reuse them.
package ram_access_arbiter_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_access_arbiter_pick.sv
// Two-way winner select: round-robin by default, fixed priority
// to requester 0 when RAM_ARB_FIXED_PRIORITY_EN is defined.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic any,
  output logic win
);

  assign any = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb win = ~req0;
`else
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 && req1):  win = ptr;
      (req1 && !req0): win = 1'b1;
      default:         win = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-requester arbiter/sequencer for a single-port word RAM.
// Optional RAM_ARB_FIXED_PRIORITY_EN: requester 0 always wins.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_rw,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t state;
  logic   ptr;
  logic   cmd_id;
  logic   any;
  logic   win;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr),
    .any  (any),
    .win  (win)
  );

  always_ff @(posedge clk) begin
    if (!clear) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cmd_id    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      ram_rw    <= 1'b0;
      ram_sel   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // RAM outputs double as the latched command
          if (any) begin
            state     <= ACCESS;
            cmd_id    <= win;
            gnt0      <= ~win;
            gnt1      <= win;
            ram_sel   <= 1'b1;
            ram_rw    <= win ? we1 : we0;
            ram_addr  <= win ? addr1 : addr0;
            ram_wdata <= win ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state     <= DONE;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          ram_sel   <= 1'b0;
          ram_rw    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          done0     <= ~cmd_id;
          done1     <= cmd_id;
          if (!ram_rw) begin
            if (cmd_id) rdata1 <= ram_rdata;
            else        rdata0 <= ram_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
          ptr   <= ~cmd_id;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
